// File: rtl/sm_seq_divider.sv
// sm_seq_divider: multi-cycle sign-magnitude divider, restoring algorithm,
// one quotient bit per clock.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          request a division; only sampled while idle
//   a, b           dividend and divisor, sign-magnitude, sign in bit W-1
//   busy           operation in progress, including the done cycle
//   done           one-cycle pulse when quo/rem/divbyzeroflag are updated
//   quo, rem       2W-1 bit sign-magnitude results, magnitude zero-extended
//   divbyzeroflag  last completed operation had a zero-magnitude divisor
module sm_seq_divider #(
   parameter int unsigned W = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-2:0] quo,
   output logic [2*W-2:0] rem,
   output logic           divbyzeroflag
);

   localparam int unsigned M  = W - 1;
   localparam int unsigned CW = $clog2(W);
   localparam logic [CW-1:0] CntInit = CW'(M);
   localparam logic [CW-1:0] CntLast = CW'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // Dividend magnitude shifts out MSB-first; quotient bits shift in at the LSB,
   // so after M steps this register holds the quotient magnitude.
   logic [M-1:0]     dvd_q, dvd_d;
   logic [M-1:0]     dvs_q, dvs_d;
   logic [M-1:0]     prem_q, prem_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic [2*W-2:0]   quo_q, quo_d;
   logic [2*W-2:0]   rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [M:0]       shifted;
   logic [M:0]       diff;
   logic             qbit;
   logic [M-1:0]     prem_step;
   logic [M-1:0]     quo_step;

   // Zero magnitude always yields an all-zero word, so no negative zero escapes.
   function automatic logic [2*W-2:0] fmt(input logic s, input logic [M-1:0] mag);
      if (mag == '0) begin
         return '0;
      end
      return {s, {M{1'b0}}, mag};
   endfunction

   // One restoring step. The partial remainder is always below the divisor, so
   // the M+1 bit difference has its sign bit set exactly when the subtract borrows.
   always_comb begin
      shifted   = {prem_q, dvd_q[M-1]};
      diff      = shifted - {1'b0, dvs_q};
      qbit      = ~diff[M];
      prem_step = qbit ? diff[M-1:0] : shifted[M-1:0];
      quo_step  = {dvd_q[M-2:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               dvd_d   = a[M-1:0];
               dvs_d   = b[M-1:0];
               qsign_d = a[W-1] ^ b[W-1];
               rsign_d = a[W-1];
               cnt_d   = CntInit;
               prem_d  = '0;
               if (b[M-1:0] == '0) begin
                  quo_d   = '0;
                  rem_d   = '0;
                  dbz_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            prem_d = prem_step;
            dvd_d  = quo_step;
            cnt_d  = cnt_q - CntLast;
            if (cnt_q == CntLast) begin
               quo_d   = fmt(qsign_q, quo_step);
               rem_d   = fmt(rsign_q, prem_step);
               dbz_d   = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign quo           = quo_q;
   assign rem           = rem_q;
   assign divbyzeroflag = dbz_q;

endmodule

// File: tb/tb_sm_seq_divider.sv
// Directed bench for sm_seq_divider at W=3 and W=5.
module tb_sm_seq_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start3 = 1'b0;
   logic [2:0] a3 = '0, b3 = '0;
   logic       busy3, done3, dbz3;
   logic [4:0] quo3, rem3;

   logic       start5 = 1'b0;
   logic [4:0] a5 = '0, b5 = '0;
   logic       busy5, done5, dbz5;
   logic [8:0] quo5, rem5;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sm_seq_divider #(.W(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .quo(quo3), .rem(rem3), .divbyzeroflag(dbz3)
   );

   sm_seq_divider #(.W(5)) dut5 (
      .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5),
      .busy(busy5), .done(done5), .quo(quo5), .rem(rem5), .divbyzeroflag(dbz5)
   );

   // Issue one operation on the W=3 instance; returns at the negedge where done
   // is seen. lat = edges from the accepting edge, -1 on timeout.
   task automatic run3(input logic [2:0] av, input logic [2:0] bv,
                       output int lat, output int bcnt);
      for (int i = 0; i < 10 && busy3; i++) @(negedge clk);
      a3 = av; b3 = bv; start3 = 1'b1;
      lat = -1; bcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start3 = 1'b0;
         if (busy3) bcnt++;
         if (done3) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run5(input logic [4:0] av, input logic [4:0] bv, output int lat);
      for (int i = 0; i < 10 && busy5; i++) @(negedge clk);
      a5 = av; b5 = bv; start5 = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start5 = 1'b0;
         if (done5) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if ({busy3, done3, quo3, rem3, dbz3} !== 13'd0)
         $display("FAIL reset_w3: got %b want 0", {busy3, done3, quo3, rem3, dbz3});
      else pass_cnt++;
      total_cnt++;
      if ({busy5, done5, quo5, rem5, dbz5} !== 21'd0)
         $display("FAIL reset_w5: got %b want 0", {busy5, done5, quo5, rem5, dbz5});
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bcnt;
      run3(3'b011, 3'b110, lat, bcnt);
      total_cnt++;
      if (lat !== 3) $display("FAIL basic_latency: got %0d want 3", lat);
      else pass_cnt++;
      total_cnt++;
      if (bcnt !== 3) $display("FAIL basic_busy_cycles: got %0d want 3", bcnt);
      else pass_cnt++;
      total_cnt++;
      if ({quo3, rem3, dbz3} !== {5'b10001, 5'b00001, 1'b0})
         $display("FAIL basic_result: got %b_%b_%b want 10001_00001_0", quo3, rem3, dbz3);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({busy3, done3, quo3, rem3} !== {2'b00, 5'b10001, 5'b00001})
         $display("FAIL basic_after_done: got %b want 00_10001_00001",
                  {busy3, done3, quo3, rem3});
      else pass_cnt++;
   endtask

   task automatic test_signs();
      logic [2:0] av [3] = '{3'b111, 3'b101, 3'b100};
      logic [2:0] bv [3] = '{3'b010, 3'b011, 3'b011};
      logic [4:0] eq [3] = '{5'b10001, 5'b00000, 5'b00000};
      logic [4:0] er [3] = '{5'b10001, 5'b10001, 5'b00000};
      int lat, bcnt;
      for (int k = 0; k < 3; k++) begin
         run3(av[k], bv[k], lat, bcnt);
         total_cnt++;
         if (lat !== 3 || quo3 !== eq[k] || rem3 !== er[k] || dbz3 !== 1'b0)
            $display("FAIL signs a=%b b=%b: got lat=%0d quo=%b rem=%b dbz=%b want lat=3 quo=%b rem=%b dbz=0",
                     av[k], bv[k], lat, quo3, rem3, dbz3, eq[k], er[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_divzero();
      logic [2:0] bv [2] = '{3'b000, 3'b100};
      int lat, bcnt;
      for (int k = 0; k < 2; k++) begin
         run3(3'b011, bv[k], lat, bcnt);
         total_cnt++;
         if (lat !== 1 || quo3 !== 5'b0 || rem3 !== 5'b0 || dbz3 !== 1'b1)
            $display("FAIL divzero b=%b: got lat=%0d quo=%b rem=%b dbz=%b want lat=1 0 0 1",
                     bv[k], lat, quo3, rem3, dbz3);
         else pass_cnt++;
      end
      run3(3'b011, 3'b010, lat, bcnt);
      total_cnt++;
      if (dbz3 !== 1'b0 || quo3 !== 5'b00001 || rem3 !== 5'b00001)
         $display("FAIL divzero_clear: got quo=%b rem=%b dbz=%b want 00001 00001 0",
                  quo3, rem3, dbz3);
      else pass_cnt++;
   endtask

   task automatic test_wide();
      int lat;
      run5(5'b01111, 5'b10100, lat);
      total_cnt++;
      if (lat !== 5) $display("FAIL wide_latency: got %0d want 5", lat);
      else pass_cnt++;
      total_cnt++;
      if (quo5 !== 9'b1_0000_0011 || rem5 !== 9'b0_0000_0011 || dbz5 !== 1'b0)
         $display("FAIL wide_result: got quo=%b rem=%b dbz=%b want 100000011 000000011 0",
                  quo5, rem5, dbz5);
      else pass_cnt++;
   endtask

   task automatic test_sweep();
      int lat, bcnt, elat;
      logic [1:0] am, bm, qm, rm;
      logic [4:0] eq, er;
      logic       ed;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            run3(3'(i), 3'(j), lat, bcnt);
            am = 2'(i); bm = 2'(j);
            if (bm == 2'd0) begin
               eq = '0; er = '0; ed = 1'b1; elat = 1;
            end else begin
               qm = am / bm; rm = am % bm;
               eq = (qm == 2'd0) ? 5'd0 : {i[2] ^ j[2], 2'b00, qm};
               er = (rm == 2'd0) ? 5'd0 : {i[2], 2'b00, rm};
               ed = 1'b0; elat = 3;
            end
            total_cnt++;
            if (lat !== elat || quo3 !== eq || rem3 !== er || dbz3 !== ed)
               $display("FAIL sweep a=%b b=%b: got lat=%0d quo=%b rem=%b dbz=%b want lat=%0d quo=%b rem=%b dbz=%b",
                        3'(i), 3'(j), lat, quo3, rem3, dbz3, elat, eq, er, ed);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] bv [2] = '{3'b010, 3'b000};
      int espace [2] = '{4, 2};
      int efirst [2] = '{3, 1};
      int first, second;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 10 && busy3; i++) @(negedge clk);
         a3 = 3'b011; b3 = bv[k]; start3 = 1'b1;
         first = -1; second = -1;
         for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done3) begin
               if (first < 0) first = i;
               else begin
                  second = i;
                  break;
               end
            end
         end
         start3 = 1'b0;
         total_cnt++;
         if (first !== efirst[k] || second - first !== espace[k])
            $display("FAIL back_to_back b=%b: got first=%0d spacing=%0d want first=%0d spacing=%0d",
                     bv[k], first, second - first, efirst[k], espace[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_midrun();
      int lat, bcnt;
      run3(3'b111, 3'b010, lat, bcnt);
      for (int i = 0; i < 10 && busy3; i++) @(negedge clk);
      a3 = 3'b011; b3 = 3'b110; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({busy3, done3, quo3, rem3, dbz3} !== 13'd0)
         $display("FAIL reset_midrun: got %b want 0", {busy3, done3, quo3, rem3, dbz3});
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      run3(3'b011, 3'b010, lat, bcnt);
      total_cnt++;
      if (lat !== 3 || quo3 !== 5'b00001 || rem3 !== 5'b00001)
         $display("FAIL reset_recover: got lat=%0d quo=%b rem=%b want 3 00001 00001",
                  lat, quo3, rem3);
      else pass_cnt++;
   endtask

   task automatic test_ignore_busy();
      int lat;
      for (int i = 0; i < 10 && busy3; i++) @(negedge clk);
      a3 = 3'b011; b3 = 3'b110; start3 = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start3 = (i == 1);
         if (i == 1) begin
            a3 = 3'b111; b3 = 3'b001;
         end
         if (done3) begin
            lat = i;
            break;
         end
      end
      start3 = 1'b0;
      total_cnt++;
      if (lat !== 3 || quo3 !== 5'b10001 || rem3 !== 5'b00001)
         $display("FAIL ignore_busy: got lat=%0d quo=%b rem=%b want 3 10001 00001",
                  lat, quo3, rem3);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_divzero();
      test_wide();
      test_sweep();
      test_back_to_back();
      test_reset_midrun();
      test_ignore_busy();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
